// File: rtl/gameover_pkg.sv
// Shared types and widths for the game-over banner overlay.
package gameover_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLIDE = 2'd1,
    SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing coordinates as seen by overlay layers; the timing generator drives the out side.
interface vga_if;

  logic [gameover_pkg::COORD_W-1:0] hcount;
  logic [gameover_pkg::COORD_W-1:0] vcount;

  modport out (output hcount, output vcount);
  modport in  (input  hcount, input  vcount);

endinterface

// File: rtl/gameover_anim_ctrl.sv
// Animation control for the game-over panel: frame tick, slide FSM, drop offset and
// the optional border blink counter (enabled by GAMEOVER_BLINK_EN).
module gameover_anim_ctrl
  import gameover_pkg::*;
#(
  parameter int Y0           = 300,
  parameter int SLIDE_STEP   = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               trigger,
  input  logic               clear,
  output state_t             state,
  output logic [COORD_W-1:0] drop,
  output logic               blink_phase,
  output logic               active,
  output logic               shown
);

  localparam logic [COORD_W-1:0] Y0_C   = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] STEP_C = COORD_W'(SLIDE_STEP);

  logic               tick_r;
  state_t             state_r;
  state_t             state_nxt;
  logic [COORD_W-1:0] drop_r;
  logic [COORD_W-1:0] drop_nxt;
  logic               active_r;
  logic               shown_r;

  // Frame tick: one cycle after the timing source shows the top-left pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_r <= 1'b0;
    end else begin
      tick_r <= (hcount == COORD_W'(0)) && (vcount == COORD_W'(0));
    end
  end

  // Next-state and next-drop selection; clear overrides trigger and tick
  always_comb begin
    state_nxt = state_r;
    drop_nxt  = drop_r;
    if (clear) begin
      state_nxt = IDLE;
      drop_nxt  = COORD_W'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (trigger) begin
            if (Y0_C == COORD_W'(0)) begin
              state_nxt = SHOW;
              drop_nxt  = COORD_W'(0);
            end else begin
              state_nxt = SLIDE;
              drop_nxt  = Y0_C;
            end
          end else begin
            state_nxt = IDLE;
            drop_nxt  = drop_r;
          end
        end
        SLIDE: begin
          if (tick_r) begin
            if (drop_r <= STEP_C) begin
              state_nxt = SHOW;
              drop_nxt  = COORD_W'(0);
            end else begin
              state_nxt = SLIDE;
              drop_nxt  = drop_r - STEP_C;
            end
          end else begin
            state_nxt = SLIDE;
            drop_nxt  = drop_r;
          end
        end
        SHOW: begin
          state_nxt = SHOW;
          drop_nxt  = drop_r;
        end
        default: begin
          state_nxt = IDLE;
          drop_nxt  = COORD_W'(0);
        end
      endcase
    end
  end

  // State, drop and status flags; flags follow the next state so they move with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      drop_r   <= COORD_W'(0);
      active_r <= 1'b0;
      shown_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      drop_r   <= drop_nxt;
      active_r <= (state_nxt != IDLE);
      shown_r  <= (state_nxt == SHOW);
    end
  end

`ifdef GAMEOVER_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

  logic [CNT_W-1:0] blink_cnt_r;
  logic             blink_phase_r;

  // Blink counter: restarts outside a settled SHOW, wraps every BLINK_FRAMES ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_r   <= CNT_W'(0);
      blink_phase_r <= 1'b0;
    end else if ((state_r != SHOW) || (state_nxt != SHOW)) begin
      blink_cnt_r   <= CNT_W'(0);
      blink_phase_r <= 1'b0;
    end else if (tick_r) begin
      if (blink_cnt_r == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_r   <= CNT_W'(0);
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + CNT_W'(1);
        blink_phase_r <= blink_phase_r;
      end
    end else begin
      blink_cnt_r   <= blink_cnt_r;
      blink_phase_r <= blink_phase_r;
    end
  end

  assign blink_phase = blink_phase_r;
`else
  assign blink_phase = 1'b0;
`endif

  assign state  = state_r;
  assign drop   = drop_r;
  assign active = active_r;
  assign shown  = shown_r;

endmodule

// File: rtl/draw_gameover_panel.sv
// Animated game-over banner overlay: classifies each pixel against the sliding panel and
// registers colour/ownership. Optional border blink is enabled by GAMEOVER_BLINK_EN.
module draw_gameover_panel
  import gameover_pkg::*;
#(
  parameter int               X0           = 400,
  parameter int               Y0           = 300,
  parameter int               W            = 200,
  parameter int               H            = 100,
  parameter int               BORDER       = 4,
  parameter logic [RGB_W-1:0] FILL_RGB     = 12'h00F,
  parameter logic [RGB_W-1:0] BORDER_RGB   = 12'hFFF,
  parameter int               SLIDE_STEP   = 8,
  parameter int               BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst,
  vga_if.in                vin,
  input  logic             trigger,
  input  logic             clear,
  output logic [RGB_W-1:0] rgb,
  output logic             valid,
  output logic             active,
  output logic             shown
);

  // One extra bit keeps X0+W and Y0+H from wrapping
  localparam int XW = COORD_W + 1;

  localparam logic [XW-1:0] X_LO    = XW'(X0);
  localparam logic [XW-1:0] X_HI    = XW'(X0 + W);
  localparam logic [XW-1:0] X_LO_IN = XW'(X0 + BORDER);
  localparam logic [XW-1:0] X_HI_IN = XW'(X0 + W - BORDER);

  state_t             state;
  logic [COORD_W-1:0] drop;
  logic               blink_phase;

  logic [XW-1:0]    x_s;
  logic [XW-1:0]    y_s;
  logic [XW-1:0]    y_top_s;
  logic [XW-1:0]    y_bot_s;
  logic             inside_s;
  logic             on_border_s;
  logic [RGB_W-1:0] border_col_s;
  logic [RGB_W-1:0] pix_rgb_s;
  logic [RGB_W-1:0] rgb_r;
  logic             valid_r;

  gameover_anim_ctrl #(
    .Y0           (Y0),
    .SLIDE_STEP   (SLIDE_STEP),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_anim (
    .clk         (clk),
    .rst         (rst),
    .hcount      (vin.hcount),
    .vcount      (vin.vcount),
    .trigger     (trigger),
    .clear       (clear),
    .state       (state),
    .drop        (drop),
    .blink_phase (blink_phase),
    .active      (active),
    .shown       (shown)
  );

  // Pixel classification against the current panel position; drop never exceeds Y0
  always_comb begin
    x_s          = {1'b0, vin.hcount};
    y_s          = {1'b0, vin.vcount};
    y_top_s      = XW'(Y0) - {1'b0, drop};
    y_bot_s      = y_top_s + XW'(H);
    inside_s     = (x_s >= X_LO) && (x_s < X_HI) && (y_s >= y_top_s) && (y_s < y_bot_s);
    on_border_s  = inside_s &&
                   ((x_s < X_LO_IN) || (x_s >= X_HI_IN) ||
                    (y_s < (y_top_s + XW'(BORDER))) || (y_s >= (y_bot_s - XW'(BORDER))));
    border_col_s = BORDER_RGB;
    if (blink_phase) begin
      border_col_s = FILL_RGB;
    end else begin
      border_col_s = BORDER_RGB;
    end
    pix_rgb_s = 12'h000;
    if (on_border_s) begin
      pix_rgb_s = border_col_s;
    end else if (inside_s) begin
      pix_rgb_s = FILL_RGB;
    end else begin
      pix_rgb_s = 12'h000;
    end
  end

  // Output pixel registers: one clock of latency from the timing coordinates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_r   <= 12'h000;
      valid_r <= 1'b0;
    end else begin
      rgb_r   <= pix_rgb_s;
      valid_r <= inside_s && (state != IDLE);
    end
  end

  assign rgb   = rgb_r;
  assign valid = valid_r;

endmodule

// File: doc/draw_gameover_panel.md
Name: draw_gameover_panel

Overview:
Animated, parametrised game-over banner overlay for the VGA pipeline. On a game-over trigger, a bordered rectangle slides down from the top of the screen to its rest position, one step per frame, and then stays on screen until cleared. Downstream, the overlay mux uses the `rgb`/`valid` pixel stream to select between this block and the game layers.

Parameters:
- X0, 400, left edge of the panel (px, inclusive)
- Y0, 300, top edge of the panel at rest (px, inclusive)
- W, 200, panel width (px); horizontal span is [X0, X0+W)
- H, 100, panel height (px)
- BORDER, 4, border thickness (px); must satisfy 0 ≤ BORDER < min(W,H)/2
- FILL_RGB, 12'h00F, interior colour
- BORDER_RGB, 12'hFFF, border colour
- SLIDE_STEP, 8, pixels the panel descends per frame; must be ≥ 1
- BLINK_FRAMES, 30, frames per blink half-period; must be ≥ 1; used only with the optional feature

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- vin  vga_if.in  -  timing source; hcount/vcount are 11-bit unsigned
- trigger  in  1  single-cycle pulse: start the game-over animation
- clear  in  1  single-cycle pulse: remove the panel and return to idle
- rgb  out  12  pixel colour, registered
- valid  out  1  high when this block owns the current pixel, registered
- active  out  1  high in SLIDE or SHOW
- shown  out  1  high in SHOW (panel has reached its rest position)

Behaviour:
- Reset, applied asynchronously while rst=0:
  - rgb=0, valid=0, active=0, shown=0
  - state=IDLE, drop=0, blink counter=0, blink phase=0
- Frame tick: one-cycle internal pulse, registered, asserted the cycle after vin shows hcount==0 && vcount==0.
  - drop, state transitions driven by the tick, and blink state change only on tick cycles.
  - Panel geometry is therefore constant within a frame.
- FSM states:
  - IDLE: panel not drawn. On trigger: drop←Y0, go to SLIDE. If Y0==0, go directly to SHOW.
  - SLIDE: on each tick, if drop ≤ SLIDE_STEP then drop←0 and go to SHOW; otherwise drop←drop−SLIDE_STEP.
  - SHOW: holds indefinitely.
- clear: in any state, next state is IDLE and drop←0.
  - clear has priority over trigger and over a tick in the same cycle.
- trigger while in SLIDE or SHOW: ignored.
- Panel vertical span: [Y0−drop, Y0−drop+H).
  - drop ≤ Y0 always holds, so there is no underflow.
  - All compares are 11-bit unsigned; bounds are computed 12 bits wide to avoid overflow at X0+W or Y0+H.
- Pixel classification, performed on the current vin coordinates:
  - inside = within the horizontal span and the vertical span.
  - edge = inside AND within BORDER px of any panel edge.
- Output update:
  - valid ← inside && state≠IDLE.
  - rgb ← BORDER_RGB if edge, FILL_RGB if inside and not edge, 12'h000 otherwise.
- Latency: exactly 1 clk from vin to rgb/valid.
- active and shown are registered and change in the cycle the state changes.
- Boundaries:
  - Right and bottom edges are exclusive.
  - With BORDER=0, no edge pixels exist.
  - A trigger arriving mid-frame takes effect immediately: panel at top from the next pixel.

Optional Feature:
- Macro: GAMEOVER_BLINK_EN.
- Defined:
  - In SHOW, a frame counter counts 0..BLINK_FRAMES−1 on ticks and toggles the blink phase on wrap.
  - When phase=1, edge pixels use FILL_RGB.
  - Counter and phase are reset on entry to SHOW and in IDLE.
- Undefined: no counter logic exists; the border is always BORDER_RGB.

Decomposition:
- gameover_pkg holds:
  - enum state_t {IDLE, SLIDE, SHOW}
  - constant COORD_W=11
  - constant RGB_W=12
- Sub-module gameover_anim_ctrl holds the FSM, frame-tick detect, drop register and blink counter.
  - Outputs to the parent: state, drop, blink phase.
- The top level holds the pixel-classification datapath and the output registers.

Test Plan:
1. Reset and idle: pulse rst low mid-frame → rgb=0, valid=0, active=0 immediately. With no trigger, pixel (500,350) → valid=0.
2. Slide timing (defaults): trigger → in the same frame pixel (500,5) gives valid=1, rgb=00F. After the first tick, the panel top is at row 8. shown rises on the 38th tick (300/8 rounded up). From then on the top is at row 300.
3. Rest-position colours in SHOW:
   - (401,350) → FFF
   - (500,350) → 00F
   - (599,399) → FFF
   - (600,350) → valid=0
   - (500,400) → valid=0
4. Clear priority: clear and trigger in the same cycle during SHOW → IDLE next cycle, valid=0 for the rest of the frame. A later trigger restarts the slide from top row 0.
5. Ignored trigger and edge-case parameters:
   - Trigger during SLIDE → drop sequence unchanged.
   - Y0=0 → trigger goes straight to SHOW.
   - BORDER=0 → no FFF pixels.
6. With GAMEOVER_BLINK_EN defined: border pixel (401,350) reads FFF for 30 frames, then 00F for 30, then FFF again. Interior stays 00F throughout.
